// File: rtl/breakout_pkg.sv
// Shared types and helpers for the Breakout brick-field display path.
package breakout_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StWon  = 2'd2
  } game_state_e;

  localparam logic [23:0] DefColorA  = 24'hFF0000;
  localparam logic [23:0] DefColorB  = 24'hFFFFFF;
  localparam logic [23:0] DefColorFg = 24'hFFFFFF;
  localparam logic [23:0] DefColorBg = 24'h000000;

  // Bit position of brick (row, col) in the alive bitmap.
  function automatic int unsigned brick_idx(input int unsigned row, input int unsigned col,
                                            input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/brick_locator.sv
// Finds which brick slot a coordinate falls in along one axis, by boundary compares.
module brick_locator #(
  parameter int unsigned COUNT   = 8,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned ORIGIN  = 0,
  parameter int unsigned SIZE    = 80,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [COORD_W-1:0] i_coord,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_in
);

  logic [31:0] w_coord;

  assign w_coord = 32'(i_coord);

  // Last boundary not beyond the coordinate gives the slot index.
  always_comb begin
    o_idx = '0;
    o_in  = ((w_coord + 32'd1) > ORIGIN) && (w_coord < ORIGIN + COUNT * SIZE);
    for (int unsigned k = 1; k < COUNT; k++) begin
      if (w_coord >= ORIGIN + k * SIZE) begin
        o_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/brick_field_renderer.sv
// Breakout brick grid, game FSM and 2-stage per-pixel colour pipeline.
module brick_field_renderer
  import breakout_pkg::*;
#(
  parameter int unsigned ROWS     = 3,
  parameter int unsigned COLS     = 8,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned ORIGIN_X = 0,
  parameter int unsigned ORIGIN_Y = 0,
  parameter int unsigned BRICK_W  = 80,
  parameter int unsigned BRICK_H  = 50,
  parameter int unsigned PADDLE_W = 160,
  parameter int unsigned PADDLE_H = 10,
  parameter int unsigned BALL_R   = 3,
  parameter logic [23:0] COLOR_A  = DefColorA,
  parameter logic [23:0] COLOR_B  = DefColorB,
  parameter logic [23:0] COLOR_FG = DefColorFg,
  parameter logic [23:0] COLOR_BG = DefColorBg,
  localparam int unsigned NB = ROWS * COLS,
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned LW = $clog2(NB + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_pix_valid,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_ballx,
  input  logic [COORD_W-1:0] i_bally,
  input  logic [COORD_W-1:0] i_paddlex,
  input  logic [COORD_W-1:0] i_paddley,
  input  logic               i_hit_valid,
  input  logic [RW-1:0]      i_hit_row,
  input  logic [CW-1:0]      i_hit_col,
  output logic [NB-1:0]      o_alive,
  output logic [LW-1:0]      o_bricks_left,
  output logic [1:0]         o_game_state,
  output logic               o_won_pulse,
  output logic               o_color_valid,
  output logic [23:0]        o_color
);

  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned XW = COORD_W + 1;
  localparam logic [RW:0] RowsL = (RW + 1)'(ROWS);
  localparam logic [CW:0] ColsL = (CW + 1)'(COLS);
  localparam logic [XW-1:0] PadW = XW'(PADDLE_W);
  localparam logic [XW-1:0] PadH = XW'(PADDLE_H);
  localparam logic [XW-1:0] BallR = XW'(BALL_R);

  game_state_e   r_state;
  logic [NB-1:0] r_alive;
  logic [LW-1:0] r_left;
  logic          r_won;

  logic          r_s1_valid;
  logic          r_s1_paddle;
  logic          r_s1_ball;
  logic          r_s1_in_grid;
  logic [RW-1:0] r_s1_row;
  logic [CW-1:0] r_s1_col;
  logic          r_c_valid;
  logic [23:0]   r_color;

  // ---------------------------------------------------------------------------
  // Hit decode and game FSM
  // ---------------------------------------------------------------------------
  logic          w_hit_in_range;
  logic [IW-1:0] w_hit_idx;
  logic          w_hit_ok;

  assign w_hit_in_range = ({1'b0, i_hit_row} < RowsL) && ({1'b0, i_hit_col} < ColsL);
  assign w_hit_idx      = IW'(brick_idx(32'(i_hit_row), 32'(i_hit_col), COLS));
  assign w_hit_ok       = i_hit_valid && w_hit_in_range && r_alive[w_hit_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_alive <= '1;
      r_left  <= LW'(NB);
      r_won   <= 1'b0;
    end else begin
      r_won <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StPlay;
            r_alive <= '1;
            r_left  <= LW'(NB);
          end
        end
        StPlay: begin
          if (r_left == '0) begin
            r_state <= StWon;
            r_won   <= 1'b1;
          end else if (w_hit_ok) begin
            r_alive[w_hit_idx] <= 1'b0;
            r_left             <= r_left - LW'(1);
          end
        end
        StWon: begin
          if (i_start) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: object hit tests, evaluated one bit wider than the coordinates
  // ---------------------------------------------------------------------------
  logic [XW-1:0] w_x, w_y, w_bx, w_by, w_px, w_py;
  logic          w_paddle;
  logic          w_ball;
  logic          w_x_in, w_y_in;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_bx = {1'b0, i_ballx};
  assign w_by = {1'b0, i_bally};
  assign w_px = {1'b0, i_paddlex};
  assign w_py = {1'b0, i_paddley};

  assign w_paddle = (w_x >= w_px) && (w_x < w_px + PadW) &&
                    (w_y >= w_py) && (w_y < w_py + PadH);
  assign w_ball   = (w_x + BallR > w_bx) && (w_x < w_bx + BallR) &&
                    (w_y + BallR > w_by) && (w_y < w_by + BallR);

  brick_locator #(
    .COUNT  (COLS),
    .COORD_W(COORD_W),
    .ORIGIN (ORIGIN_X),
    .SIZE   (BRICK_W),
    .IDX_W  (CW)
  ) u_loc_x (
    .i_coord(i_x),
    .o_idx  (w_col),
    .o_in   (w_x_in)
  );

  brick_locator #(
    .COUNT  (ROWS),
    .COORD_W(COORD_W),
    .ORIGIN (ORIGIN_Y),
    .SIZE   (BRICK_H),
    .IDX_W  (RW)
  ) u_loc_y (
    .i_coord(i_y),
    .o_idx  (w_row),
    .o_in   (w_y_in)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: colour priority, using the live bitmap and state at this edge
  // ---------------------------------------------------------------------------
  logic [IW-1:0] w_cell_idx;
  logic          w_draw_bricks;
  logic [23:0]   w_color;

  assign w_cell_idx    = IW'(brick_idx(32'(r_s1_row), 32'(r_s1_col), COLS));
  assign w_draw_bricks = (r_state != StWon);

  always_comb begin
    w_color = COLOR_BG;
    if (r_s1_paddle) begin
      w_color = COLOR_FG;
    end else if (r_s1_ball) begin
      w_color = COLOR_FG;
    end else if (r_s1_in_grid && w_draw_bricks && r_alive[w_cell_idx]) begin
      w_color = (r_s1_row[0] ^ r_s1_col[0]) ? COLOR_B : COLOR_A;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_paddle  <= 1'b0;
      r_s1_ball    <= 1'b0;
      r_s1_in_grid <= 1'b0;
      r_s1_row     <= '0;
      r_s1_col     <= '0;
      r_c_valid    <= 1'b0;
      r_color      <= COLOR_BG;
    end else begin
      r_s1_valid   <= i_pix_valid;
      r_s1_paddle  <= w_paddle;
      r_s1_ball    <= w_ball;
      r_s1_in_grid <= w_x_in && w_y_in;
      r_s1_row     <= w_row;
      r_s1_col     <= w_col;
      r_c_valid    <= r_s1_valid;
      if (r_s1_valid) begin
        r_color <= w_color;
      end
    end
  end

  assign o_alive       = r_alive;
  assign o_bricks_left = r_left;
  assign o_game_state  = r_state;
  assign o_won_pulse   = r_won;
  assign o_color_valid = r_c_valid;
  assign o_color       = r_color;

endmodule

// File: tb/tb_brick_field_renderer.sv
// Directed bench for brick_field_renderer with a per-cycle reference model.
module tb_brick_field_renderer;

  localparam int ROWS = 3;
  localparam int COLS = 8;
  localparam int NB   = ROWS * COLS;
  localparam logic [23:0] CA  = 24'hFF0000;
  localparam logic [23:0] CB  = 24'hFFFFFF;
  localparam logic [23:0] CFG = 24'hFFFFFF;
  localparam logic [23:0] CBG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, hit_valid;
  logic [9:0]  x, y, ballx, bally, paddlex, paddley;
  logic [1:0]  hit_row;
  logic [2:0]  hit_col;
  logic [23:0] alive;
  logic [4:0]  bricks_left;
  logic [1:0]  game_state;
  logic        won_pulse, color_valid;
  logic [23:0] color;

  always #5 clk = ~clk;

  brick_field_renderer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_pix_valid  (pix_valid),
    .i_x          (x),
    .i_y          (y),
    .i_ballx      (ballx),
    .i_bally      (bally),
    .i_paddlex    (paddlex),
    .i_paddley    (paddley),
    .i_hit_valid  (hit_valid),
    .i_hit_row    (hit_row),
    .i_hit_col    (hit_col),
    .o_alive      (alive),
    .o_bricks_left(bricks_left),
    .o_game_state (game_state),
    .o_won_pulse  (won_pulse),
    .o_color_valid(color_valid),
    .o_color      (color)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: geometry by plain division, game rules by popcount.
  function automatic logic [23:0] model_color(input int px, input int py, input int bx,
                                              input int by, input int qx, input int qy,
                                              input int st, input logic [23:0] al);
    int r, c;
    if (qx >= px && qx < px + 160 && qy >= py && qy < py + 10) return CFG;
    if (qx + 3 > bx && qx < bx + 3 && qy + 3 > by && qy < by + 3) return CFG;
    if (st != 2 && qx < COLS * 80 && qy < ROWS * 50) begin
      r = qy / 50;
      c = qx / 80;
      if (al[r * COLS + c]) return ((r + c) % 2 == 1) ? CB : CA;
    end
    return CBG;
  endfunction

  logic        m_init = 1'b0;
  int          m_state;
  logic [23:0] m_alive;
  logic        m_won, m_cvalid;
  logic [23:0] m_color;
  logic        p1_valid;
  int          p1_x, p1_y, p1_bx, p1_by, p1_px, p1_py;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init   = 1'b1;
        m_state  = 0;
        m_alive  = '1;
        m_won    = 1'b0;
        m_cvalid = 1'b0;
        m_color  = CBG;
        p1_valid = 1'b0;
      end else if (m_init) begin
        if (p1_valid) m_color = model_color(p1_px, p1_py, p1_bx, p1_by, p1_x, p1_y,
                                            m_state, m_alive);
        m_cvalid = p1_valid;
        p1_valid = pix_valid;
        p1_x  = int'(x);       p1_y  = int'(y);
        p1_bx = int'(ballx);   p1_by = int'(bally);
        p1_px = int'(paddlex); p1_py = int'(paddley);
        m_won = 1'b0;
        case (m_state)
          0: if (start) begin m_state = 1; m_alive = '1; end
          1: begin
            if ($countones(m_alive) == 0) begin
              m_state = 2;
              m_won   = 1'b1;
            end else if (hit_valid && int'(hit_row) < ROWS && int'(hit_col) < COLS) begin
              m_alive[int'(hit_row) * COLS + int'(hit_col)] = 1'b0;
            end
          end
          default: if (start) m_state = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("m_state", 32'(game_state), 32'(m_state));
        chk("m_alive", 32'(alive), 32'(m_alive));
        chk("m_left", 32'(bricks_left), 32'($countones(m_alive)));
        chk("m_won", 32'(won_pulse), 32'(m_won));
        chk("m_cvalid", 32'(color_valid), 32'(m_cvalid));
        chk("m_color", 32'(color), 32'(m_color));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic query(input int qx, input int qy, input logic [23:0] exp, input string name);
    x = 10'(qx);
    y = 10'(qy);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_valid"}, 32'(color_valid), 32'd1);
    chk(name, 32'(color), 32'(exp));
    #1;
  endtask

  task automatic hit(input int r, input int c);
    hit_row   = 2'(r);
    hit_col   = 3'(c);
    hit_valid = 1'b1;
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; hit_valid = 1'b0;
    x = '0; y = '0; hit_row = '0; hit_col = '0;
    paddlex = 10'd0; paddley = 10'd400; ballx = 10'd600; bally = 10'd450;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state", 32'(game_state), 32'd0);
    chk("rst_left", 32'(bricks_left), 32'd24);
    chk("rst_alive", 32'(alive), 32'hFFFFFF);
    chk("rst_cvalid", 32'(color_valid), 32'd0);
    chk("rst_color", 32'(color), 32'd0);

    query(85, 10, 24'hFFFFFF, "brick01");
    query(5, 5, 24'hFF0000, "brick00");

    hit(0, 0);
    chk("idle_hit_left", 32'(bricks_left), 32'd24);
    chk("idle_hit_alive", 32'(alive), 32'hFFFFFF);

    pulse_start();
    chk("play_state", 32'(game_state), 32'd1);
    hit(0, 0);
    chk("hit00_left", 32'(bricks_left), 32'd23);
    chk("hit00_alive0", 32'(alive[0]), 32'd0);
    query(5, 5, 24'h000000, "dead00");
    hit(0, 0);
    chk("rehit_left", 32'(bricks_left), 32'd23);
    hit(3, 0);
    chk("oor_left", 32'(bricks_left), 32'd23);
    chk("oor_alive", 32'(alive), 32'hFFFFFE);

    paddlex = 10'd100; paddley = 10'd140; ballx = 10'd102; bally = 10'd142;
    query(102, 142, 24'hFFFFFF, "paddle_ball");
    hit(2, 3);
    query(260, 145, 24'h000000, "paddle_edge_out");
    query(259, 145, 24'hFFFFFF, "paddle_edge_in");

    paddlex = 10'd300; paddley = 10'd400; ballx = 10'd202; bally = 10'd120;
    query(204, 120, 24'hFFFFFF, "ball_edge_in");
    query(205, 120, 24'hFF0000, "ball_edge_out");
    query(199, 120, 24'hFF0000, "ball_left_out");
    ballx = 10'd600; bally = 10'd450;

    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        hit(r, c);
      end
    end
    chk("all_hit_left", 32'(bricks_left), 32'd0);
    chk("all_hit_state", 32'(game_state), 32'd1);
    @(posedge clk);
    #1;
    chk("won_state", 32'(game_state), 32'd2);
    chk("won_pulse_hi", 32'(won_pulse), 32'd1);
    @(posedge clk);
    #1;
    chk("won_pulse_lo", 32'(won_pulse), 32'd0);
    #1;
    query(300, 400, 24'hFFFFFF, "won_paddle");

    pulse_start();
    chk("won_to_idle", 32'(game_state), 32'd0);
    pulse_start();
    chk("replay_state", 32'(game_state), 32'd1);
    chk("replay_left", 32'(bricks_left), 32'd24);
    chk("replay_alive", 32'(alive), 32'hFFFFFF);

    x = 10'd85; y = 10'd10; pix_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cvalid", 32'(color_valid), 32'd0);
    chk("midrst_color", 32'(color), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cvalid1", 32'(color_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_cvalid2", 32'(color_valid), 32'd1);
    chk("post_rst_color", 32'(color), 32'hFFFFFF);
    #1;
    pix_valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
